alu_issue_stage: RTL and testbench

//  ID->EX issue register directly upstream of the 64-bit ALU. Accepts decoded RV64I integer ops
//  (OP, OP-IMM, LUI, AUIPC), selects operands, and maps funct3/funct7 to the 4-bit ALU control.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_skid_buf.sv | 79 +++++++
 rtl/alu_issue_stage.sv | 117 +++++++++++
 tb/tb_alu_issue_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode constants, ALU control
// encodings, the issued-op payload and the skid-buffer state type.
package alu_pkg;

    localparam int XLEN    = 64;
    localparam int SHAMT_W = 6;

    // RV64I integer opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 values accepted on register-register ops
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU control = {alt, funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    // One decoded op as handed to the ALU
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      control;
        logic [4:0]      rd;
        logic            illegal;
    } issue_entry_t;

    localparam int ISSUE_W = $bits(issue_entry_t);

endpackage

// File: rtl/alu_skid_buf.sv
// Generic two-entry valid/ready skid buffer. Both in_ready and out_valid are
// registered, so neither handshake side sees a combinational path through it.
// Handshake: a transfer happens on a side in every cycle where valid and ready
// are both high at the rising edge; valid never waits on ready.
module alu_skid_buf
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [W-1:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [W-1:0] out_data,
    output skid_state_e state
);

    logic [W-1:0] skid_q;
    logic         in_fire;
    logic         out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Occupancy FSM; main entry drives out_data directly, skid holds the younger op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        out_data <= in_data;
                    end else if (in_fire) begin
                        skid_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= ST_TWO;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // input is stalled here; only the older op can leave
                    if (out_fire) begin
                        out_data <= skid_q;
                        in_ready <= 1'b1;
                        state    <= ST_ONE;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage for the 64-bit ALU: decodes OP/OP-IMM/LUI/AUIPC into
// operands and a 4-bit ALU control, then queues the result in a two-entry
// skid buffer. Optional writeback bypass at accept: ALU_ISSUE_FWD_EN.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_control,
    output logic [4:0]      out_rd,
    output logic            out_illegal,
    output logic [1:0]      dbg_state
);

    logic [XLEN-1:0] rs1_v;
    logic [XLEN-1:0] rs2_v;
    logic            is_shift;
    issue_entry_t    dec;
    issue_entry_t    held;
    skid_state_e     buf_state;

`ifdef ALU_ISSUE_FWD_EN
    // Writeback bypass: x0 is never forwarded
    always_comb begin
        rs1_v = in_rs1_val;
        rs2_v = in_rs2_val;
        if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_rs1)) rs1_v = fwd_data;
        if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_rs2)) rs2_v = fwd_data;
    end
`else
    logic fwd_unused;
    assign fwd_unused = ^{fwd_valid, fwd_rd, fwd_data, in_rs1, in_rs2};
    assign rs1_v = in_rs1_val;
    assign rs2_v = in_rs2_val;
`endif

    assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    // Operand selection and funct3/funct7 -> ALU control mapping
    always_comb begin
        dec    = '0;
        dec.rd = in_rd;
        case (in_opcode)
            OPC_OP: begin
                if ((in_funct7 == F7_BASE) || (in_funct7 == F7_ALT)) begin
                    dec.a       = rs1_v;
                    dec.b       = rs2_v;
                    dec.control = {((in_funct3 == 3'b000) || (in_funct3 == 3'b101)) & in_funct7[5],
                                   in_funct3};
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // ADDI has no subtract form; only SRAI uses the alt bit (imm[10])
                dec.a       = rs1_v;
                dec.b       = in_imm;
                dec.control = {(in_funct3 == 3'b101) & in_imm[10], in_funct3};
            end
            OPC_LUI: begin
                dec.b       = in_imm;
                dec.control = ALU_ADD;
            end
            OPC_AUIPC: begin
                dec.a       = in_pc;
                dec.b       = in_imm;
                dec.control = ALU_ADD;
            end
            default: dec.illegal = 1'b1;
        endcase
        // shifts only carry the shift amount; upper bits are cleared
        if (is_shift && !dec.illegal && ((in_opcode == OPC_OP) || (in_opcode == OPC_OP_IMM))) begin
            dec.b = {{(XLEN-SHAMT_W){1'b0}}, dec.b[SHAMT_W-1:0]};
        end
    end

    alu_skid_buf #(.W(ISSUE_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (held),
        .state     (buf_state)
    );

    assign out_a       = held.a;
    assign out_b       = held.b;
    assign out_control = held.control;
    assign out_rd      = held.rd;
    assign out_illegal = held.illegal;
    assign dbg_state   = buf_state;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed cases with literal expectations plus a
// randomized phase checked every cycle against a queue-based model.
module tb_alu_issue_stage;

    localparam int XLEN = 64;
    localparam int EW   = 2*XLEN + 4 + 5 + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [6:0]      in_opcode = '0;
    logic [2:0]      in_funct3 = '0;
    logic [6:0]      in_funct7 = '0;
    logic [4:0]      in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [XLEN-1:0] in_rs1_val = '0, in_rs2_val = '0, in_imm = '0, in_pc = '0;
    logic            fwd_valid = 1'b0;
    logic [4:0]      fwd_rd = '0;
    logic [XLEN-1:0] fwd_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_a, out_b;
    logic [3:0]      out_control;
    logic [4:0]      out_rd;
    logic            out_illegal;
    logic [1:0]      dbg_state;

    int checks = 0;
    int failures = 0;

    // expected entries packed as {a, b, control, rd, illegal}, oldest first
    logic [EW-1:0] exp_q[$];

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_pc(in_pc),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_control(out_control),
        .out_rd(out_rd), .out_illegal(out_illegal), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the instruction-set rules
    function automatic logic [EW-1:0] model_op();
        logic [XLEN-1:0] r1, r2, a, b;
        logic [3:0] ctl;
        logic ill;
        r1 = in_rs1_val;
        r2 = in_rs2_val;
`ifdef ALU_ISSUE_FWD_EN
        if (fwd_valid && fwd_rd != 0 && fwd_rd == in_rs1) r1 = fwd_data;
        if (fwd_valid && fwd_rd != 0 && fwd_rd == in_rs2) r2 = fwd_data;
`endif
        a = 0; b = 0; ctl = 0; ill = 0;
        if (in_opcode == 7'b0110011) begin
            if (in_funct7 == 7'h00 || in_funct7 == 7'h20) begin
                a = r1;
                b = (in_funct3 == 1 || in_funct3 == 5) ? (r2 % 64) : r2;
                ctl = {1'b0, in_funct3};
                if ((in_funct3 == 0 || in_funct3 == 5) && in_funct7 == 7'h20) ctl[3] = 1'b1;
            end else ill = 1;
        end else if (in_opcode == 7'b0010011) begin
            a = r1;
            b = (in_funct3 == 1 || in_funct3 == 5) ? (in_imm % 64) : in_imm;
            ctl = {1'b0, in_funct3};
            if (in_funct3 == 5 && in_imm[10]) ctl[3] = 1'b1;
        end else if (in_opcode == 7'b0110111) begin
            b = in_imm;
        end else if (in_opcode == 7'b0010111) begin
            a = in_pc;
            b = in_imm;
        end else ill = 1;
        return {a, b, ctl, in_rd, ill};
    endfunction

    // Per-cycle compare against the model, then advance the model past the coming edge
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic do_pop, do_push;
        if (rst) begin
            exp_q.delete();
        end else begin
            check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            check("dbg_state", 64'(dbg_state), 64'(exp_q.size()));
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                check("out_a", out_a, e[EW-1 -: XLEN]);
                check("out_b", out_b, e[EW-1-XLEN -: XLEN]);
                check("out_control", 64'(out_control), 64'(e[9:6]));
                check("out_rd", 64'(out_rd), 64'(e[5:1]));
                check("out_illegal", 64'(out_illegal), 64'(e[0]));
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                do_pop  = out_ready && exp_q.size() != 0;
                do_push = in_valid && exp_q.size() < 2;
                if (do_pop) void'(exp_q.pop_front());
                if (do_push) exp_q.push_back(model_op());
            end
        end
    end

    // driver: inputs change only 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [63:0] v1, input logic [63:0] v2,
                            input logic [63:0] imm, input logic [63:0] pc);
        in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_val = v1; in_rs2_val = v2; in_imm = imm; in_pc = pc;
    endtask

    task automatic send_and_look(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [63:0] v1, input logic [63:0] v2,
                                 input logic [63:0] imm, input logic [63:0] pc);
        drive_op(op, f3, f7, rs1, rs2, rd, v1, v2, imm, pc);
        step();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // reset
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_a", out_a, 64'd0);
        check("rst out_b", out_b, 64'd0);
        check("rst out_control", 64'(out_control), 64'd0);
        check("rst out_rd", 64'(out_rd), 64'd0);
        check("rst out_illegal", 64'(out_illegal), 64'd0);
        step();
        rst = 1'b0;
        step();

        // SUB
        send_and_look(7'b0110011, 3'b000, 7'b0100000, 5'd1, 5'd2, 5'd7, 64'd10, 64'd3, 64'd0, 64'd0);
        check("sub valid", 64'(out_valid), 64'd1);
        check("sub ctl", 64'(out_control), 64'b1000);
        check("sub a", out_a, 64'd10);
        check("sub b", out_b, 64'd3);
        check("sub rd", 64'(out_rd), 64'd7);
        step();

        // SRAI with shamt 70 -> 6
        send_and_look(7'b0010011, 3'b101, 7'b0100000, 5'd1, 5'd0, 5'd2, 64'h1234, 64'd0, 64'h446, 64'd0);
        check("srai ctl", 64'(out_control), 64'b1101);
        check("srai b", out_b, 64'd6);
        check("srai a", out_a, 64'h1234);
        step();

        // AUIPC
        send_and_look(7'b0010111, 3'b000, 7'b0000000, 5'd0, 5'd0, 5'd3, 64'd99, 64'd0, 64'h5000, 64'h1000);
        check("auipc a", out_a, 64'h1000);
        check("auipc b", out_b, 64'h5000);
        check("auipc ctl", 64'(out_control), 64'd0);
        step();

        // OP with unsupported funct7
        send_and_look(7'b0110011, 3'b000, 7'b0000001, 5'd1, 5'd2, 5'd4, 64'd5, 64'd6, 64'd0, 64'd0);
        check("illegal flag", 64'(out_illegal), 64'd1);
        check("illegal ctl", 64'(out_control), 64'd0);
        check("illegal a", out_a, 64'd0);
        step();

        // forwarding onto rs1, and x0 never forwarded
        fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 64'hAB;
        send_and_look(7'b0010011, 3'b000, 7'b0000000, 5'd5, 5'd0, 5'd1, 64'h11, 64'd0, 64'd0, 64'd0);
`ifdef ALU_ISSUE_FWD_EN
        check("fwd a", out_a, 64'hAB);
`else
        check("fwd ignored a", out_a, 64'h11);
`endif
        step();
        fwd_rd = 5'd0;
        send_and_look(7'b0010011, 3'b000, 7'b0000000, 5'd0, 5'd0, 5'd1, 64'h22, 64'd0, 64'd0, 64'd0);
        check("fwd x0 a", out_a, 64'h22);
        fwd_valid = 1'b0;
        step();

        // backpressure: three ops, out_ready low
        out_ready = 1'b0;
        drive_op(7'b0010011, 3'b000, 7'b0, 5'd1, 5'd0, 5'd1, 64'd1, 64'd0, 64'd0, 64'd0);
        step();
        in_rs1_val = 64'd2; in_rd = 5'd2;
        step();
        in_rs1_val = 64'd3; in_rd = 5'd3;
        @(negedge clk);
        check("bp in_ready low", 64'(in_ready), 64'd0);
        check("bp head 1", out_a, 64'd1);
        step();
        @(negedge clk);
        check("bp hold head 1", out_a, 64'd1);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release head 1", out_a, 64'd1);
        step();
        @(negedge clk);
        check("bp head 2", out_a, 64'd2);
        check("bp in_ready back", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp head 3", out_a, 64'd3);
        step();
        step();

        // flush while full with a new op offered
        out_ready = 1'b0;
        drive_op(7'b0110011, 3'b000, 7'b0, 5'd1, 5'd2, 5'd1, 64'd40, 64'd2, 64'd0, 64'd0);
        step();
        step();
        flush = 1'b1;
        in_rs1_val = 64'd77;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("flush no late op", 64'(out_valid), 64'd0);
        step();

        // asynchronous reset while holding two ops
        out_ready = 1'b0;
        drive_op(7'b0110111, 3'b000, 7'b0, 5'd0, 5'd0, 5'd9, 64'd0, 64'd0, 64'h7000, 64'd0);
        step();
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst in_ready", 64'(in_ready), 64'd1);
        step();
        rst = 1'b0;
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 40) == 0);
            case ($urandom_range(0, 5))
                0, 5: in_opcode = 7'b0110011;
                1:    in_opcode = 7'b0010011;
                2:    in_opcode = 7'b0110111;
                3:    in_opcode = 7'b0010111;
                default: in_opcode = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                1:       in_funct7 = 7'h20;
                2:       in_funct7 = 7'($urandom);
                default: in_funct7 = 7'h00;
            endcase
            in_funct3  = 3'($urandom);
            in_rs1     = 5'($urandom_range(0, 3));
            in_rs2     = 5'($urandom_range(0, 3));
            in_rd      = 5'($urandom);
            in_rs1_val = {$urandom, $urandom};
            in_rs2_val = {$urandom, $urandom};
            in_imm     = {$urandom, $urandom};
            in_pc      = {$urandom, $urandom};
            fwd_valid  = 1'($urandom);
            fwd_rd     = 5'($urandom_range(0, 3));
            fwd_data   = {$urandom, $urandom};
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("drained", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
